// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared definitions for the AES-128 key expansion block:
//     NR_AES128 : number of AES-128 rounds (10)
//     state_e   : key-expansion FSM encoding (IDLE, EMIT)
//     rcon_f    : round-constant table, Rcon[1..10]; any other index gives 00
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int NR_AES128 = 10;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Round constants, most-significant byte of the Rcon word.
  function automatic logic [7:0] rcon_f(input logic [3:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// ---------------------------------------------------------------------------
// aes_key_expand_if
//   Request / round-key stream bundle of aes_key_expand.
//     start     : request to expand key_in            (master -> slave)
//     key_in    : 128-bit cipher key, w0 in [127:96]   (master -> slave)
//     rk_ready  : consumer accepts current round key   (master -> slave)
//     busy      : expansion in progress                (slave -> master)
//     rk_valid  : round_key / rk_index are valid       (slave -> master)
//     round_key : current round key, same byte order   (slave -> master)
//     rk_index  : round number 0..NR of round_key      (slave -> master)
//     done      : one-cycle pulse after the last key   (slave -> master)
// ---------------------------------------------------------------------------
interface aes_key_expand_if;

  logic         start;
  logic [127:0] key_in;
  logic         rk_ready;
  logic         busy;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   rk_index;
  logic         done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, round_key, rk_index, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, round_key, rk_index, done
  );

endinterface

// File: rtl/aes_sbox_comb.sv
// ---------------------------------------------------------------------------
// aes_sbox_comb
//   Purely combinational AES forward S-box.
//     in_i  : 8-bit input byte
//     out_o : 8-bit substituted byte
// ---------------------------------------------------------------------------
module aes_sbox_comb (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_key_expand.sv
// ---------------------------------------------------------------------------
// aes_key_expand
//   Iterative AES-128 key schedule. A start in IDLE captures key_in; the block
//   then presents RK0..RKNR one at a time on a valid/ready stream, computing
//   the next round key only when the current one is accepted.
//     clk       : rising-edge clock
//     rst       : asynchronous active-high reset
//     kx        : aes_key_expand_if.slave (start, key_in, rk_ready in;
//                 busy, rk_valid, round_key, rk_index, done out)
//   Parameter NR: number of rounds; only 10 (AES-128) is meaningful.
// ---------------------------------------------------------------------------
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic             clk,
  input  logic             rst,
  aes_key_expand_if.slave  kx
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_e       state_q, state_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] key_q, key_d;
  logic         done_q, done_d;

  // Next-round-key datapath: the only S-box path, from key_q back to key_d.
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w, sub_w, t_w;
  logic [31:0]  w4, w5, w6, w7;
  logic [127:0] next_key;

  assign w0    = key_q[127:96];
  assign w1    = key_q[95:64];
  assign w2    = key_q[63:32];
  assign w3    = key_q[31:0];
  assign rot_w = {w3[23:0], w3[31:24]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    aes_sbox_comb u_sbox (
      .in_i  (rot_w[8*b +: 8]),
      .out_o (sub_w[8*b +: 8])
    );
  end

  // idx_q holds the round of the key on display, so the key being built is
  // round idx_q+1. At the last index the rcon value is never consumed.
  assign t_w      = sub_w ^ {rcon_f(idx_q + 4'd1), 24'h000000};
  assign w4       = w0 ^ t_w;
  assign w5       = w1 ^ w4;
  assign w6       = w2 ^ w5;
  assign w7       = w3 ^ w6;
  assign next_key = {w4, w5, w6, w7};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      key_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      key_q   <= key_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    key_d        = key_q;
    done_d       = 1'b0;
    kx.rk_valid  = 1'b0;
    kx.busy      = 1'b0;
    kx.round_key = '0;
    kx.rk_index  = 4'd0;
    kx.done      = done_q;

    case (state_q)
      IDLE: begin
        // The done cycle still belongs to the finished expansion, so a start
        // arriving with done high is dropped.
        if (kx.start && !done_q) begin
          key_d   = kx.key_in;
          idx_d   = 4'd0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        kx.rk_valid  = 1'b1;
        kx.busy      = 1'b1;
        kx.round_key = key_q;
        kx.rk_index  = idx_q;
        if (kx.rk_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = next_key;
            idx_d = idx_q + 4'd1;
          end
        end
      end
    endcase
  end

endmodule
